// File: rtl/car_lane_pkg.sv
// Shared types and defaults for the lane animator.
// Pure declarations: no logic, no latency.
// No flow control; constants only.
package car_lane_pkg;

    // Entry-side insertion sequencer states.
    typedef enum logic [1:0] {
        READY = 2'd0,
        ADD   = 2'd1,
        SPACE = 2'd2
    } lane_state_e;

    localparam int LANE_LEN_DEF  = 14;
    localparam int LANE_ROWS_DEF = 2;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/car_lane_shift.sv
// Lane occupancy shift register with stop-line blocking chain.
// Latency: one traffic_clk per cell of motion; entry write lands on the next edge.
// Backpressure: entry_free drops when the entry cell holds a car that is queued
// solidly back to the stop line; the writer must not write while it is low.
//   traffic_clk, reset_n : clock, async active-low reset
//   go                   : 1 = all cells advance, 0 = hold the queue at the stop line
//   entry_we, entry_val  : write of the entry cell (LANE_LEN-1)
//   occ                  : occupancy, bit 0 = exit cell
//   entry_free           : entry cell will accept a write this cycle
module car_lane_shift #(
    parameter int LANE_LEN = 14,
    parameter int STOP_POS = 6
) (
    input  logic                traffic_clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic                entry_we,
    input  logic                entry_val,
    output logic [LANE_LEN-1:0] occ,
    output logic                entry_free
);

    logic [LANE_LEN-1:0] blocked;
    logic [LANE_LEN-1:0] occ_nxt;

    // A cell is blocked when it sits on an unbroken run of occupied cells that
    // reaches back to the waiting position at STOP_POS+1 under a red light.
    // Cells at or below STOP_POS are past the line and never block.
    always_comb begin : blk_chain
        logic run;
        run     = 1'b0;
        blocked = '0;
        for (int i = STOP_POS + 1; i < LANE_LEN; i++) begin
            if (i == STOP_POS + 1) begin
                run = ~go;
            end else begin
                run = run & occ[i-1];
            end
            blocked[i] = run;
        end
    end

    assign entry_free = ~(occ[LANE_LEN-1] & blocked[LANE_LEN-1]);

    // Blocked occupied cells keep their car; every other cell takes whatever
    // moves down from above. Cell 0 simply falls off the end.
    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < LANE_LEN - 1; i++) begin
            occ_nxt[i] = (occ[i] & blocked[i]) | (occ[i+1] & ~blocked[i+1]);
        end
        occ_nxt[LANE_LEN-1] = (occ[LANE_LEN-1] & blocked[LANE_LEN-1])
                            | (entry_we & entry_val);
    end

    always_ff @(posedge traffic_clk or negedge reset_n) begin
        if (!reset_n) begin
            occ <= '0;
        end else begin
            occ <= occ_nxt;
        end
    end

endmodule

// File: rtl/car_lane_animate.sv
// One-lane traffic animator: inserts CAR_LEN-cell cars plus GAP spacing, queues at red.
// Latency: a car accepted at edge k occupies the entry cell from edge k+1.
// Backpressure: add_ready low while the entry is jammed or a car is mid-insert.
//   traffic_clk, reset_n : clock, async active-low reset
//   add_car, go          : insert request (level), green/red light
//   add_ready            : a request would be accepted this cycle
//   decrement_car        : one pulse per car as its first cell enters
//   lane_empty           : no occupied cell and no insertion in progress
//   car_move_array       : per-row occupancy, bit-reversed when DIR=1
module car_lane_animate
    import car_lane_pkg::*;
#(
    parameter int LANE_LEN  = LANE_LEN_DEF,
    parameter int LANE_ROWS = LANE_ROWS_DEF,
    parameter int CAR_LEN   = 2,
    parameter int GAP       = 1,
    parameter int STOP_POS  = 6,
    parameter int DIR       = 0
) (
    input  logic                                traffic_clk,
    input  logic                                reset_n,
    input  logic                                add_car,
    input  logic                                go,
    output logic                                add_ready,
    output logic                                decrement_car,
    output logic                                lane_empty,
    output logic [LANE_ROWS-1:0][LANE_LEN-1:0]  car_move_array
);

    localparam int CNT_MAX = (CAR_LEN > GAP) ? CAR_LEN : GAP;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] CAR_LAST = CNT_W'(CAR_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

    lane_state_e          state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 entry_we;
    logic                 entry_val;
    logic                 entry_free;
    logic [LANE_LEN-1:0]  occ;
    logic [LANE_LEN-1:0]  row_val;

    car_lane_shift #(
        .LANE_LEN (LANE_LEN),
        .STOP_POS (STOP_POS)
    ) u_shift (
        .traffic_clk (traffic_clk),
        .reset_n     (reset_n),
        .go          (go),
        .entry_we    (entry_we),
        .entry_val   (entry_val),
        .occ         (occ),
        .entry_free  (entry_free)
    );

    always_ff @(posedge traffic_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Every state advances only when the entry is free, so a stalled car
    // keeps its position in the sequence and is never split or re-counted.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        entry_we      = 1'b0;
        entry_val     = 1'b0;
        decrement_car = 1'b0;
        add_ready     = 1'b0;
        case (state)
            READY: begin
                if (entry_free) begin
                    entry_we  = 1'b1;
                    add_ready = 1'b1;
                    if (add_car) begin
                        state_nxt = ADD;
                        cnt_nxt   = '0;
                    end
                end
            end
            ADD: begin
                if (entry_free) begin
                    entry_we      = 1'b1;
                    entry_val     = 1'b1;
                    decrement_car = (cnt == '0);
                    if (cnt == CAR_LAST) begin
                        state_nxt = SPACE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            SPACE: begin
                if (entry_free) begin
                    entry_we = 1'b1;
                    if (cnt == GAP_LAST) begin
                        // Last gap cell: a waiting request chains straight into the next car.
                        add_ready = 1'b1;
                        state_nxt = add_car ? ADD : READY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = READY;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign lane_empty = (occ == '0) && (state == READY);

    always_comb begin
        row_val = occ;
        if (DIR != 0) begin
            for (int j = 0; j < LANE_LEN; j++) begin
                row_val[j] = occ[LANE_LEN-1-j];
            end
        end
        for (int r = 0; r < LANE_ROWS; r++) begin
            car_move_array[r] = row_val;
        end
    end

endmodule
